// File: rtl/regfile_mp.sv
// Multi-port register file: NRD combinational read ports, two prioritised write ports, reset-time clear sweep.
// Optional macro REGFILE_BYPASS_EN enables write-to-read forwarding in the write cycle.
module regfile_mp #(
   parameter int DATA_W        = 32,
   parameter int ADDR_W        = 5,
   parameter int NRD           = 2,
   parameter int HARDWIRE_ZERO = 1
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [NRD*ADDR_W-1:0] raddr,
   output logic [NRD*DATA_W-1:0] rdata,
   input  logic                  we0,
   input  logic [ADDR_W-1:0]     waddr0,
   input  logic [DATA_W-1:0]     wdata0,
   input  logic                  we1,
   input  logic [ADDR_W-1:0]     waddr1,
   input  logic [DATA_W-1:0]     wdata1,
   output logic                  ready,
   output logic                  wr_drop
);

   localparam int DEPTH = 2 ** ADDR_W;
   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

   typedef enum logic {CLEAR, READY} state_t;

   state_t              state_q, state_d;
   logic [ADDR_W-1:0]   clr_ptr_q;
   logic                wr_drop_q;
   logic                wen0, wen1;
   logic [DATA_W-1:0]   mem [DEPTH];

   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q   <= CLEAR;
         clr_ptr_q <= '0;
         wr_drop_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         if (state_q == CLEAR && clr_ptr_q != LAST_ADDR)
            clr_ptr_q <= clr_ptr_q + ADDR_W'(1);
         wr_drop_q <= (we0 || we1) && (state_q != READY);
      end
   end

   // NOTE: defaults first so no path through the case leaves state_d unassigned (no latch).
   always_comb begin
      state_d = state_q;
      case (state_q)
         CLEAR:   if (clr_ptr_q == LAST_ADDR) state_d = READY;
         READY:   state_d = READY;
         default: state_d = CLEAR;
      endcase
   end

   assign ready   = (state_q == READY);
   assign wr_drop = wr_drop_q;

   // Port 1 wins a same-address collision; writes to register 0 vanish when it is hardwired.
   always_comb begin
      wen1 = we1 && ready && rst_n && !(HARDWIRE_ZERO != 0 && waddr1 == '0);
      wen0 = we0 && ready && rst_n && !(HARDWIRE_ZERO != 0 && waddr0 == '0)
             && !(we1 && waddr1 == waddr0);
   end

   // NOTE: the storage array has no reset term; the CLEAR sweep zeroes it one entry per cycle.
   always_ff @(posedge clk) begin
      if (state_q == CLEAR) begin
         mem[clr_ptr_q] <= '0;
      end else begin
         if (wen0) mem[waddr0] <= wdata0;
         if (wen1) mem[waddr1] <= wdata1;
      end
   end

   always_comb begin : rd_mux
      logic [ADDR_W-1:0] ra;
      logic [DATA_W-1:0] val;
      rdata = '0;
      for (int k = 0; k < NRD; k++) begin
         ra  = raddr[k*ADDR_W +: ADDR_W];
         val = '0;
         if (ready && !(HARDWIRE_ZERO != 0 && ra == '0)) begin
            val = mem[ra];
`ifdef REGFILE_BYPASS_EN
            if (we0 && waddr0 == ra) val = wdata0;
            if (we1 && waddr1 == ra) val = wdata1;
`endif
         end
         rdata[k*DATA_W +: DATA_W] = val;
      end
   end

endmodule

// File: tb/tb_regfile_mp.sv
// Self-checking bench for regfile_mp at default parameters: table of write/readback vectors
// plus hand-written reset, clear-sweep, drop and same-cycle read sequences.
module tb_regfile_mp;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [9:0]  raddr;
   logic [63:0] rdata;
   logic        we0, we1;
   logic [4:0]  waddr0, waddr1;
   logic [31:0] wdata0, wdata1;
   logic        ready, wr_drop;

   int n_vec = 0;
   int n_err = 0;

   regfile_mp dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .raddr  (raddr),
      .rdata  (rdata),
      .we0    (we0),
      .waddr0 (waddr0),
      .wdata0 (wdata0),
      .we1    (we1),
      .waddr1 (waddr1),
      .wdata1 (wdata1),
      .ready  (ready),
      .wr_drop(wr_drop)
   );

   always #5 clk = ~clk;

   typedef struct {
      string       name;
      logic [31:0] e0;
      logic [31:0] e1;
   } rd_exp_t;

   rd_exp_t sb[$];

   typedef struct {
      logic        we0;
      logic [4:0]  waddr0;
      logic [31:0] wdata0;
      logic        we1;
      logic [4:0]  waddr1;
      logic [31:0] wdata1;
      logic [4:0]  ra0;
      logic [4:0]  ra1;
      logic [31:0] exp0;
      logic [31:0] exp1;
   } vec_t;

   vec_t vecs[7];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic expect_read(input string name, input logic [4:0] a0, input logic [4:0] a1,
                              input logic [31:0] e0, input logic [31:0] e1);
      rd_exp_t r;
      raddr  = {a1, a0};
      r.name = name;
      r.e0   = e0;
      r.e1   = e1;
      sb.push_back(r);
   endtask

   task automatic compare_read();
      rd_exp_t r;
      #1;
      if (sb.size() == 0) begin
         n_vec++;
         n_err++;
         $display("FAIL scoreboard_empty: got no pending read expected one");
      end else begin
         r = sb.pop_front();
         check({r.name, "_p0"}, rdata[31:0], r.e0);
         check({r.name, "_p1"}, rdata[63:32], r.e1);
      end
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      we0   = 1'b0;
      we1   = 1'b0;
      cyc();
      cyc();
      rst_n = 1'b1;
   endtask

   initial begin
      rst_n = 1'b0; raddr = '0;
      we0 = 1'b0; waddr0 = '0; wdata0 = '0;
      we1 = 1'b0; waddr1 = '0; wdata1 = '0;

      //            we0 wa0    wd0            we1 wa1    wd1            ra0    ra1    exp0           exp1
      vecs[0] = '{1'b1, 5'd5,  32'hDEADBEEF, 1'b0, 5'd0,  32'h0,        5'd5,  5'd0,  32'hDEADBEEF, 32'h0};
      vecs[1] = '{1'b1, 5'd7,  32'h00001111, 1'b1, 5'd7,  32'h00002222, 5'd7,  5'd5,  32'h00002222, 32'hDEADBEEF};
      vecs[2] = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd0,  32'hFFFFFFFF, 5'd0,  5'd7,  32'h0,        32'h00002222};
      vecs[3] = '{1'b1, 5'd3,  32'h000000C3, 1'b1, 5'd9,  32'h000000A5, 5'd3,  5'd9,  32'h000000C3, 32'h000000A5};
      vecs[4] = '{1'b1, 5'd31, 32'h80000001, 1'b1, 5'd0,  32'h12345678, 5'd31, 5'd0,  32'h80000001, 32'h0};
      vecs[5] = '{1'b1, 5'd0,  32'h00000077, 1'b1, 5'd30, 32'hCAFEF00D, 5'd30, 5'd0,  32'hCAFEF00D, 32'h0};
      vecs[6] = '{1'b0, 5'd1,  32'h0000BEEF, 1'b0, 5'd2,  32'h0000F00D, 5'd1,  5'd2,  32'h0,        32'h0};

      // Reset, clear sweep timing, all registers zero
      do_reset();
      check("rst_ready", {31'b0, ready}, 32'd0);
      check("rst_wr_drop", {31'b0, wr_drop}, 32'd0);
      expect_read("clear_forced", 5'd5, 5'd31, 32'h0, 32'h0);
      compare_read();
      for (int i = 1; i <= 32; i++) begin
         cyc();
         check($sformatf("t1_ready_c%0d", i), {31'b0, ready}, (i == 32) ? 32'd1 : 32'd0);
      end
      for (int r = 0; r < 32; r++) begin
         expect_read($sformatf("t1_zero_r%0d", r), 5'(r), 5'(31 - r), 32'h0, 32'h0);
         compare_read();
      end

      // Table: one write cycle, then read back on the following cycle
      for (int v = 0; v < 7; v++) begin
         we0 = vecs[v].we0; waddr0 = vecs[v].waddr0; wdata0 = vecs[v].wdata0;
         we1 = vecs[v].we1; waddr1 = vecs[v].waddr1; wdata1 = vecs[v].wdata1;
         cyc();
         we0 = 1'b0;
         we1 = 1'b0;
         check($sformatf("vec%0d_wr_drop", v), {31'b0, wr_drop}, 32'd0);
         expect_read($sformatf("vec%0d_rd", v), vecs[v].ra0, vecs[v].ra1, vecs[v].exp0, vecs[v].exp1);
         compare_read();
      end

      // Same-cycle read of a register being written
      we1 = 1'b1; waddr1 = 5'd9; wdata1 = 32'h0000005A;
`ifdef REGFILE_BYPASS_EN
      expect_read("t6_same_cycle", 5'd7, 5'd9, 32'h00002222, 32'h0000005A);
`else
      expect_read("t6_same_cycle", 5'd7, 5'd9, 32'h00002222, 32'h000000A5);
`endif
      compare_read();
      cyc();
      we1 = 1'b0;
      expect_read("t6_next_cycle", 5'd7, 5'd9, 32'h00002222, 32'h0000005A);
      compare_read();

      // Writes during CLEAR are dropped; reset mid-sweep restarts it
      do_reset();
      for (int i = 1; i <= 9; i++) cyc();
      we0 = 1'b1; waddr0 = 5'd3; wdata0 = 32'h1;
      cyc();
      we0 = 1'b0;
      check("t5_drop_c11", {31'b0, wr_drop}, 32'd1);
      cyc();
      check("t5_drop_clears", {31'b0, wr_drop}, 32'd0);
      we1 = 1'b1; waddr1 = 5'd0; wdata1 = 32'h5;
      cyc();
      we1 = 1'b0;
      check("t5_drop_port1", {31'b0, wr_drop}, 32'd1);
      for (int i = 14; i <= 19; i++) cyc();
      check("t5_ready_mid", {31'b0, ready}, 32'd0);
      rst_n = 1'b0;
      cyc();
      rst_n = 1'b1;
      for (int i = 1; i <= 32; i++) begin
         cyc();
         if (i >= 30)
            check($sformatf("t5_ready_c%0d", i), {31'b0, ready}, (i == 32) ? 32'd1 : 32'd0);
      end
      expect_read("t5_cleared_a", 5'd3, 5'd9, 32'h0, 32'h0);
      compare_read();
      expect_read("t5_cleared_b", 5'd5, 5'd31, 32'h0, 32'h0);
      compare_read();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
